// File: rtl/engagement_pkg.sv
// ---------------------------------------------------------------------------
// engagement_pkg
// Shared definitions for the engagement controller slice:
//   - state encoding of the engagement FSM (also visible on eng_state)
//   - default 3-D engagement zone bounds
//   - clog2 helper used to size counters from their parameters
// ---------------------------------------------------------------------------
package engagement_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_TRACK    = 3'd1;
  localparam logic [STATE_W-1:0] ST_ARMED    = 3'd2;
  localparam logic [STATE_W-1:0] ST_FIRE     = 3'd3;
  localparam logic [STATE_W-1:0] ST_COOLDOWN = 3'd4;

  localparam logic [15:0] ZONE_X_MIN = 16'd100;
  localparam logic [15:0] ZONE_X_MAX = 16'd900;
  localparam logic [15:0] ZONE_Y_MIN = 16'd100;
  localparam logic [15:0] ZONE_Y_MAX = 16'd900;
  localparam logic [15:0] ZONE_Z_MIN = 16'd50;
  localparam logic [15:0] ZONE_Z_MAX = 16'd500;

  // Ceiling log2, never below 1 so that a counter always has at least one bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/engage_zone_check.sv
// ---------------------------------------------------------------------------
// engage_zone_check
// Purely combinational 3-axis bound comparator. A point is in the zone when
// every coordinate lies inside its [MIN, MAX] window, unsigned and inclusive.
//
// Ports:
//   x, y, z  in   16  coordinate under test (unsigned)
//   in_zone  out  1   all three axes inside their bounds
// ---------------------------------------------------------------------------
module engage_zone_check
  import engagement_pkg::*;
#(
  parameter logic [15:0] X_MIN = ZONE_X_MIN,
  parameter logic [15:0] X_MAX = ZONE_X_MAX,
  parameter logic [15:0] Y_MIN = ZONE_Y_MIN,
  parameter logic [15:0] Y_MAX = ZONE_Y_MAX,
  parameter logic [15:0] Z_MIN = ZONE_Z_MIN,
  parameter logic [15:0] Z_MAX = ZONE_Z_MAX
) (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  output logic        in_zone
);

  logic x_ok;
  logic y_ok;
  logic z_ok;

  assign x_ok = (x >= X_MIN) && (x <= X_MAX);
  assign y_ok = (y >= Y_MIN) && (y <= Y_MAX);
  assign z_ok = (z >= Z_MIN) && (z <= Z_MAX);

  assign in_zone = x_ok && y_ok && z_ok;

endmodule

// File: rtl/engagement_controller.sv
// ---------------------------------------------------------------------------
// engagement_controller
// Consumes tracker samples over a valid/ready handshake, qualifies the
// predicted position against the engagement zone, arms after ARM_COUNT
// consecutive in-zone accepted samples, fires a fixed-width pulse on operator
// consent, then enforces a cooldown before re-arming is possible. The aim
// point is latched at the firing sample and a saturating shot count is kept
// against the magazine size.
//
// Ports:
//   clk, reset_n                 in   clock, async active-low reset
//   lock_active                  in   target lock held
//   x_curr, y_curr, z_curr       in   current position (monitor only)
//   x_pred, y_pred, z_pred       in   predicted position, qualified vs zone
//   data_in_valid                in   upstream sample valid
//   data_in_ready                out  sample accepted this cycle if valid
//   fire_enable                  in   operator consent (level)
//   fire_cmd                     out  fire pulse, FIRE_PULSE_CYCLES wide
//   aim_x, aim_y, aim_z          out  aim point latched at fire
//   armed                        out  registered, high while ARMED
//   ammo_empty                   out  magazine exhausted
//   shots_fired                  out  saturating shot counter
//   eng_state                    out  current FSM state
// ---------------------------------------------------------------------------
module engagement_controller
  import engagement_pkg::*;
#(
  parameter int          ARM_COUNT         = 4,
  parameter int          FIRE_PULSE_CYCLES = 4,
  parameter int          COOLDOWN_CYCLES   = 16,
  parameter int          MAX_SHOTS         = 8,
  parameter logic [15:0] X_MIN             = ZONE_X_MIN,
  parameter logic [15:0] X_MAX             = ZONE_X_MAX,
  parameter logic [15:0] Y_MIN             = ZONE_Y_MIN,
  parameter logic [15:0] Y_MAX             = ZONE_Y_MAX,
  parameter logic [15:0] Z_MIN             = ZONE_Z_MIN,
  parameter logic [15:0] Z_MAX             = ZONE_Z_MAX
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               lock_active,
  input  logic [15:0]        x_curr,
  input  logic [15:0]        y_curr,
  input  logic [15:0]        z_curr,
  input  logic [15:0]        x_pred,
  input  logic [15:0]        y_pred,
  input  logic [15:0]        z_pred,
  input  logic               data_in_valid,
  output logic               data_in_ready,
  input  logic               fire_enable,
  output logic               fire_cmd,
  output logic [15:0]        aim_x,
  output logic [15:0]        aim_y,
  output logic [15:0]        aim_z,
  output logic               armed,
  output logic               ammo_empty,
  output logic [7:0]         shots_fired,
  output logic [STATE_W-1:0] eng_state
);

  localparam int HIT_W   = clog2(ARM_COUNT + 1);
  localparam int PULSE_W = clog2(FIRE_PULSE_CYCLES + 1);
  localparam int COOL_W  = clog2(COOLDOWN_CYCLES + 1);

  localparam logic [HIT_W-1:0]   HIT_ZERO   = '0;
  localparam logic [HIT_W-1:0]   HIT_ONE    = HIT_W'(1);
  localparam logic [HIT_W-1:0]   HIT_FULL   = HIT_W'(ARM_COUNT);
  localparam logic [HIT_W-1:0]   HIT_LAST   = HIT_W'(ARM_COUNT - 1);
  localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(FIRE_PULSE_CYCLES - 1);
  localparam logic [PULSE_W-1:0] PULSE_ZERO = '0;
  localparam logic [COOL_W-1:0]  COOL_LOAD  = COOL_W'(COOLDOWN_CYCLES - 1);
  localparam logic [COOL_W-1:0]  COOL_ZERO  = '0;
  localparam logic [7:0]         SHOT_LIMIT = 8'(MAX_SHOTS);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  logic [HIT_W-1:0]   hit_cnt;
  logic [HIT_W-1:0]   hit_next;
  logic [PULSE_W-1:0] pulse_timer;
  logic [PULSE_W-1:0] pulse_next;
  logic [COOL_W-1:0]  cool_timer;
  logic [COOL_W-1:0]  cool_next;
  logic               take_shot;
  logic               in_zone;
  logic               accept;

  // Current position is carried for monitoring only; it never steers the FSM.
  logic unused_curr_monitor;
  assign unused_curr_monitor = ^{x_curr, y_curr, z_curr};

  engage_zone_check #(
    .X_MIN(X_MIN),
    .X_MAX(X_MAX),
    .Y_MIN(Y_MIN),
    .Y_MAX(Y_MAX),
    .Z_MIN(Z_MIN),
    .Z_MAX(Z_MAX)
  ) u_zone (
    .x      (x_pred),
    .y      (y_pred),
    .z      (z_pred),
    .in_zone(in_zone)
  );

  // Ready is decoded straight from the state register: the block only stalls
  // upstream while the pulse is being driven, and is ready out of reset.
  assign data_in_ready = (state != ST_FIRE);
  assign accept        = data_in_valid && data_in_ready;
  assign ammo_empty    = (shots_fired == SHOT_LIMIT);
  assign eng_state     = state;

  // Next-state and counter logic. Lock loss is checked before any sample so
  // that a sample arriving in the same cycle is consumed but ignored. The
  // pulse and cooldown timers count down to zero and the state changes on the
  // edge after the zero count, which gives exactly N cycles in each state.
  always_comb begin
    state_next = state;
    hit_next   = hit_cnt;
    pulse_next = pulse_timer;
    cool_next  = cool_timer;
    take_shot  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept && lock_active) begin
          if (in_zone) begin
            hit_next = HIT_ONE;
            if (ARM_COUNT == 1) begin
              state_next = ST_ARMED;
            end else begin
              state_next = ST_TRACK;
            end
          end else begin
            hit_next   = HIT_ZERO;
            state_next = ST_TRACK;
          end
        end
      end

      ST_TRACK: begin
        if (!lock_active) begin
          state_next = ST_IDLE;
          hit_next   = HIT_ZERO;
        end else if (accept) begin
          if (in_zone) begin
            if (hit_cnt == HIT_LAST) begin
              hit_next   = HIT_FULL;
              state_next = ST_ARMED;
            end else begin
              hit_next = hit_cnt + HIT_ONE;
            end
          end else begin
            hit_next = HIT_ZERO;
          end
        end
      end

      ST_ARMED: begin
        if (!lock_active) begin
          state_next = ST_IDLE;
          hit_next   = HIT_ZERO;
        end else if (accept) begin
          if (!in_zone) begin
            state_next = ST_TRACK;
            hit_next   = HIT_ZERO;
          end else if (fire_enable && !ammo_empty) begin
            state_next = ST_FIRE;
            pulse_next = PULSE_LOAD;
            take_shot  = 1'b1;
          end
        end
      end

      ST_FIRE: begin
        if (pulse_timer == PULSE_ZERO) begin
          state_next = ST_COOLDOWN;
          cool_next  = COOL_LOAD;
        end else begin
          pulse_next = pulse_timer - 1'b1;
        end
      end

      ST_COOLDOWN: begin
        if (cool_timer == COOL_ZERO) begin
          hit_next   = HIT_ZERO;
          state_next = lock_active ? ST_TRACK : ST_IDLE;
        end else begin
          cool_next = cool_timer - 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
        hit_next   = HIT_ZERO;
      end
    endcase
  end

  // State, counters and registered outputs. fire_cmd and armed are decoded
  // from the next state so they line up exactly with the FIRE/ARMED cycles
  // while staying glitch-free flop outputs; the async reset clears them
  // immediately, including mid-pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      hit_cnt     <= HIT_ZERO;
      pulse_timer <= PULSE_ZERO;
      cool_timer  <= COOL_ZERO;
      fire_cmd    <= 1'b0;
      armed       <= 1'b0;
      aim_x       <= 16'd0;
      aim_y       <= 16'd0;
      aim_z       <= 16'd0;
      shots_fired <= 8'd0;
    end else begin
      state       <= state_next;
      hit_cnt     <= hit_next;
      pulse_timer <= pulse_next;
      cool_timer  <= cool_next;
      fire_cmd    <= (state_next == ST_FIRE);
      armed       <= (state_next == ST_ARMED);
      if (take_shot) begin
        aim_x <= x_pred;
        aim_y <= y_pred;
        aim_z <= z_pred;
        if (shots_fired != SHOT_LIMIT) begin
          shots_fired <= shots_fired + 8'd1;
        end
      end
    end
  end

endmodule
